// File: rtl/ecc_secded_pipe_if.sv
// Bus bundle for ecc_secded_pipe: encode request/result, decode request/result and status.
// slave is the ECC block side; master is the FIFO/RAM controller side.
interface ecc_secded_pipe_if #(
  parameter int unsigned DATA_WIDTH   = 30,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH    = 16
);
  logic                               enc_valid_in;
  logic [DATA_WIDTH-1:0]              enc_data_in;
  logic                               inject_en;
  logic [DATA_WIDTH+PARITY_WIDTH-1:0] inject_mask;
  logic                               enc_valid_out;
  logic [DATA_WIDTH-1:0]              enc_data_out;
  logic [PARITY_WIDTH-1:0]            enc_parity_out;

  logic                               dec_valid_in;
  logic [DATA_WIDTH-1:0]              dec_data_in;
  logic [PARITY_WIDTH-1:0]            dec_parity_in;
  logic [TAG_WIDTH-1:0]               dec_tag_in;
  logic                               bypass;
  logic                               dec_valid_out;
  logic [DATA_WIDTH-1:0]              dec_data_out;
  logic [TAG_WIDTH-1:0]               dec_tag_out;
  logic                               dec_sbit_err;
  logic                               dec_dbit_err;

  logic                               stat_clr;
  logic [CNT_WIDTH-1:0]               sbit_cnt;
  logic [CNT_WIDTH-1:0]               dbit_cnt;
  logic                               err_log_valid;
  logic                               err_log_dbit;
  logic [PARITY_WIDTH-1:0]            err_log_syndrome;
  logic [TAG_WIDTH-1:0]               err_log_tag;

  modport slave (
    input  enc_valid_in, enc_data_in, inject_en, inject_mask,
    output enc_valid_out, enc_data_out, enc_parity_out,
    input  dec_valid_in, dec_data_in, dec_parity_in, dec_tag_in, bypass,
    output dec_valid_out, dec_data_out, dec_tag_out, dec_sbit_err, dec_dbit_err,
    input  stat_clr,
    output sbit_cnt, dbit_cnt, err_log_valid, err_log_dbit, err_log_syndrome, err_log_tag
  );

  modport master (
    output enc_valid_in, enc_data_in, inject_en, inject_mask,
    input  enc_valid_out, enc_data_out, enc_parity_out,
    output dec_valid_in, dec_data_in, dec_parity_in, dec_tag_in, bypass,
    input  dec_valid_out, dec_data_out, dec_tag_out, dec_sbit_err, dec_dbit_err,
    output stat_clr,
    input  sbit_cnt, dbit_cnt, err_log_valid, err_log_dbit, err_log_syndrome, err_log_tag
  );
endinterface

// File: rtl/ecc_secded_pipe.sv
// Pipelined SECDED (extended Hamming) encoder/decoder with error injection,
// saturating error counters and a first-error log.
module ecc_secded_pipe #(
  parameter int unsigned DATA_WIDTH   = 30,
  parameter int unsigned PARITY_WIDTH = 7,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              rst,
  ecc_secded_pipe_if.slave bus
);
  localparam int unsigned HW = PARITY_WIDTH - 1;
  localparam int unsigned CW = DATA_WIDTH + PARITY_WIDTH;

  if ((1 << HW) < CW) begin : g_bad_params
    $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH");
  end

  typedef logic [DATA_WIDTH-1:0][HW-1:0] pos_tab_t;

  // Position of data bit i: the i-th integer >= 3 that is not a power of two.
  function automatic pos_tab_t gen_pos();
    pos_tab_t    t;
    int unsigned v;
    t = '0;
    v = 3;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if ((v & (v - 1)) == 0) v = v + 1;
      t[i] = HW'(v);
      v = v + 1;
    end
    return t;
  endfunction

  localparam pos_tab_t Pos = gen_pos();

  // XOR of the positions of all set data bits equals the low check bits.
  function automatic logic [HW-1:0] hamming(input logic [DATA_WIDTH-1:0] d);
    logic [HW-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (d[i]) p = p ^ Pos[i];
    end
    return p;
  endfunction

  // Encoder
  logic [HW-1:0] enc_low;
  logic [CW-1:0] enc_word;
  logic          enc_valid_q;
  logic [CW-1:0] enc_word_q;

  always_comb begin
    enc_low  = hamming(bus.enc_data_in);
    enc_word = {^{bus.enc_data_in, enc_low}, enc_low, bus.enc_data_in};
    if (bus.inject_en) enc_word = enc_word ^ bus.inject_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_valid_q <= 1'b0;
      enc_word_q  <= '0;
    end else begin
      enc_valid_q <= bus.enc_valid_in;
      if (bus.enc_valid_in) enc_word_q <= enc_word;
    end
  end

  assign bus.enc_valid_out  = enc_valid_q;
  assign bus.enc_data_out   = enc_word_q[DATA_WIDTH-1:0];
  assign bus.enc_parity_out = enc_word_q[CW-1:DATA_WIDTH];

  // Decoder stage 1: syndrome and overall parity mismatch
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [TAG_WIDTH-1:0]  s1_tag_q;
  logic                  s1_bypass_q;
  logic [HW-1:0]         s1_syn_q;
  logic                  s1_mis_q;
  logic [HW-1:0]         s1_syn_d;
  logic                  s1_mis_d;

  always_comb begin
    s1_syn_d = hamming(bus.dec_data_in) ^ bus.dec_parity_in[HW-1:0];
    s1_mis_d = ^{bus.dec_data_in, bus.dec_parity_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s1_bypass_q <= 1'b0;
      s1_syn_q    <= '0;
      s1_mis_q    <= 1'b0;
    end else begin
      s1_valid_q <= bus.dec_valid_in;
      if (bus.dec_valid_in) begin
        s1_data_q   <= bus.dec_data_in;
        s1_tag_q    <= bus.dec_tag_in;
        s1_bypass_q <= bus.bypass;
        s1_syn_q    <= s1_syn_d;
        s1_mis_q    <= s1_mis_d;
      end
    end
  end

  // Decoder stage 2: classify and correct
  logic [DATA_WIDTH-1:0] fix;
  logic                  hit;
  logic                  chk_err;
  logic [DATA_WIDTH-1:0] s2_data_d;
  logic                  s2_sbit_d;
  logic                  s2_dbit_d;

  always_comb begin
    fix = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fix[i] = (s1_syn_q == Pos[i]);
    end
    hit       = |fix;
    // Zero or a single set bit: the flipped bit was a check bit.
    chk_err   = (s1_syn_q & (s1_syn_q - HW'(1))) == '0;
    s2_data_d = s1_data_q;
    s2_sbit_d = 1'b0;
    s2_dbit_d = 1'b0;
    if (!s1_bypass_q) begin
      if (s1_mis_q) begin
        if (hit) begin
          s2_data_d = s1_data_q ^ fix;
          s2_sbit_d = 1'b1;
        end else if (chk_err) begin
          s2_sbit_d = 1'b1;
        end else begin
          s2_dbit_d = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        s2_dbit_d = 1'b1;
      end
    end
  end

  logic                    s2_valid_q;
  logic [DATA_WIDTH-1:0]   s2_data_q;
  logic [TAG_WIDTH-1:0]    s2_tag_q;
  logic                    s2_sbit_q;
  logic                    s2_dbit_q;
  logic [PARITY_WIDTH-1:0] s2_syn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_sbit_q  <= 1'b0;
      s2_dbit_q  <= 1'b0;
      s2_syn_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
        s2_tag_q  <= s1_tag_q;
        s2_sbit_q <= s2_sbit_d;
        s2_dbit_q <= s2_dbit_d;
        s2_syn_q  <= {s1_mis_q, s1_syn_q};
      end
    end
  end

  assign bus.dec_valid_out = s2_valid_q;
  assign bus.dec_data_out  = s2_data_q;
  assign bus.dec_tag_out   = s2_tag_q;
  assign bus.dec_sbit_err  = s2_sbit_q;
  assign bus.dec_dbit_err  = s2_dbit_q;

  // Error statistics
  logic                    ev_sbit;
  logic                    ev_dbit;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q;
  logic [CNT_WIDTH-1:0]    dbit_cnt_q;
  logic                    log_valid_q;
  logic                    log_dbit_q;
  logic [PARITY_WIDTH-1:0] log_syn_q;
  logic [TAG_WIDTH-1:0]    log_tag_q;

  assign ev_sbit = s2_valid_q & s2_sbit_q;
  assign ev_dbit = s2_valid_q & s2_dbit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      log_valid_q <= 1'b0;
      log_dbit_q  <= 1'b0;
      log_syn_q   <= '0;
      log_tag_q   <= '0;
    end else if (bus.stat_clr) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      log_valid_q <= 1'b0;
      log_dbit_q  <= 1'b0;
      log_syn_q   <= '0;
      log_tag_q   <= '0;
    end else begin
      if (ev_sbit && (sbit_cnt_q != '1)) sbit_cnt_q <= sbit_cnt_q + CNT_WIDTH'(1);
      if (ev_dbit && (dbit_cnt_q != '1)) dbit_cnt_q <= dbit_cnt_q + CNT_WIDTH'(1);
      // An uncorrectable error displaces a logged correctable one.
      if ((ev_sbit || ev_dbit) && (!log_valid_q || (ev_dbit && !log_dbit_q))) begin
        log_valid_q <= 1'b1;
        log_dbit_q  <= ev_dbit;
        log_syn_q   <= s2_syn_q;
        log_tag_q   <= s2_tag_q;
      end
    end
  end

  assign bus.sbit_cnt         = sbit_cnt_q;
  assign bus.dbit_cnt         = dbit_cnt_q;
  assign bus.err_log_valid    = log_valid_q;
  assign bus.err_log_dbit     = log_dbit_q;
  assign bus.err_log_syndrome = log_syn_q;
  assign bus.err_log_tag      = log_tag_q;
endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe: encoder looped into decoder, vector table plus
// hand sequences for log overwrite, saturation (CNT_WIDTH=2 copy), stat_clr and reset.
module tb_ecc_secded_pipe;
  localparam int unsigned DW = 30;
  localparam int unsigned PW = 7;
  localparam int unsigned TW = 8;
  localparam int unsigned NV = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(16)) bus ();
  ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(2)) bus_s ();

  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ecc_secded_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .TAG_WIDTH(TW), .CNT_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  // Storage loopback: encoder output feeds decoder input.
  assign bus.dec_valid_in    = bus.enc_valid_out;
  assign bus.dec_data_in     = bus.enc_data_out;
  assign bus.dec_parity_in   = bus.enc_parity_out;
  assign bus_s.enc_valid_in  = bus.enc_valid_in;
  assign bus_s.enc_data_in   = bus.enc_data_in;
  assign bus_s.inject_en     = bus.inject_en;
  assign bus_s.inject_mask   = bus.inject_mask;
  assign bus_s.dec_tag_in    = bus.dec_tag_in;
  assign bus_s.bypass        = bus.bypass;
  assign bus_s.stat_clr      = bus.stat_clr;
  assign bus_s.dec_valid_in  = bus_s.enc_valid_out;
  assign bus_s.dec_data_in   = bus_s.enc_data_out;
  assign bus_s.dec_parity_in = bus_s.enc_parity_out;

  typedef struct {
    logic [DW-1:0]    data;
    logic             inj;
    logic [DW+PW-1:0] mask;
    logic             byp;
    logic [DW-1:0]    exp_data;
    logic             exp_s;
    logic             exp_d;
    logic [PW-1:0]    exp_syn;
  } vec_t;

  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    bus.stat_clr = 1'b1;
    @(posedge clk); #1;
    bus.stat_clr = 1'b0;
  endtask

  // Encode one word, then wait (bounded) for it to leave the decoder.
  task automatic run_word(input logic [DW-1:0] data, input logic inj, input logic [DW+PW-1:0] mask,
                          input logic byp, input logic [TW-1:0] tag, output bit ok, output int lat);
    bus.enc_data_in  = data;
    bus.inject_en    = inj;
    bus.inject_mask  = mask;
    bus.bypass       = byp;
    bus.dec_tag_in   = tag;
    bus.enc_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.enc_valid_in = 1'b0;
    bus.inject_en    = 1'b0;
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.dec_valid_out) ok = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int lat;
    bus.enc_valid_in = 1'b0;
    bus.enc_data_in  = '0;
    bus.inject_en    = 1'b0;
    bus.inject_mask  = '0;
    bus.dec_tag_in   = '0;
    bus.bypass       = 1'b0;
    bus.stat_clr     = 1'b0;

    //           data          inj   mask             byp   exp_data      s     d     syn
    vecs[0]  = '{30'h2AAAAAAA, 1'b1, 37'h0000000000, 1'b0, 30'h2AAAAAAA, 1'b0, 1'b0, 7'h00};
    vecs[1]  = '{30'h2AAAAAAA, 1'b1, 37'h0000000010, 1'b0, 30'h2AAAAAAA, 1'b1, 1'b0, 7'h49};
    vecs[2]  = '{30'h2AAAAAAA, 1'b1, 37'h0000000003, 1'b0, 30'h2AAAAAA9, 1'b0, 1'b1, 7'h06};
    vecs[3]  = '{30'h2AAAAAAA, 1'b1, 37'h0040000000, 1'b0, 30'h2AAAAAAA, 1'b1, 1'b0, 7'h41};
    vecs[4]  = '{30'h2AAAAAAA, 1'b1, 37'h1000000000, 1'b0, 30'h2AAAAAAA, 1'b1, 1'b0, 7'h40};
    vecs[5]  = '{30'h2AAAAAAA, 1'b1, 37'h0000000010, 1'b1, 30'h2AAAAABA, 1'b0, 1'b0, 7'h00};
    vecs[6]  = '{30'h15555555, 1'b1, 37'h0020000000, 1'b0, 30'h15555555, 1'b1, 1'b0, 7'h64};
    vecs[7]  = '{30'h3FFFFFFF, 1'b1, 37'h0000000800, 1'b0, 30'h3FFFFFFF, 1'b1, 1'b0, 7'h51};
    vecs[8]  = '{30'h00000000, 1'b1, 37'h1000000001, 1'b0, 30'h00000001, 1'b0, 1'b1, 7'h03};
    vecs[9]  = '{30'h12345678, 1'b1, 37'h1022000000, 1'b0, 30'h30345678, 1'b0, 1'b1, 7'h7B};
    vecs[10] = '{30'h0ABCDEF0, 1'b1, 37'h0200000000, 1'b0, 30'h0ABCDEF0, 1'b1, 1'b0, 7'h48};
    vecs[11] = '{30'h3FFFFFFF, 1'b1, 37'h0000000000, 1'b0, 30'h3FFFFFFF, 1'b0, 1'b0, 7'h00};
    vecs[12] = '{30'h2AAAAAAA, 1'b0, 37'h0000000010, 1'b0, 30'h2AAAAAAA, 1'b0, 1'b0, 7'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst enc_valid_out", 64'(bus.enc_valid_out), 64'd0);
    check("rst enc_word", 64'({bus.enc_parity_out, bus.enc_data_out}), 64'd0);
    check("rst dec_valid_out", 64'(bus.dec_valid_out), 64'd0);
    check("rst dec_data_out", 64'(bus.dec_data_out), 64'd0);
    check("rst flags", 64'({bus.dec_sbit_err, bus.dec_dbit_err}), 64'd0);
    check("rst counters", 64'({bus.sbit_cnt, bus.dbit_cnt}), 64'd0);
    check("rst log", 64'({bus.err_log_valid, bus.err_log_dbit, bus.err_log_syndrome,
                           bus.err_log_tag}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Encoder: latency, parity, hold, injection
    bus.enc_data_in  = 30'h2AAAAAAA;
    bus.enc_valid_in = 1'b1;
    @(posedge clk); #1;
    check("enc valid", 64'(bus.enc_valid_out), 64'd1);
    check("enc data", 64'(bus.enc_data_out), 64'h2AAAAAAA);
    check("enc parity", 64'(bus.enc_parity_out), 64'h4C);
    bus.enc_valid_in = 1'b0;
    bus.enc_data_in  = 30'h15555555;
    @(posedge clk); #1;
    check("enc valid drop", 64'(bus.enc_valid_out), 64'd0);
    check("enc hold", 64'(bus.enc_data_out), 64'h2AAAAAAA);
    bus.enc_data_in  = 30'h2AAAAAAA;
    bus.inject_en    = 1'b1;
    bus.inject_mask  = 37'h1000000000;
    bus.enc_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.enc_valid_in = 1'b0;
    bus.inject_en    = 1'b0;
    check("enc inject parity", 64'(bus.enc_parity_out), 64'h0C);
    repeat (4) @(posedge clk);
    #1;

    // Vector table, statistics cleared before each word
    for (int i = 0; i < NV; i++) begin
      clear_stats();
      run_word(vecs[i].data, vecs[i].inj, vecs[i].mask, vecs[i].byp, 8'(8'hA0 + i), ok, lat);
      check($sformatf("v%0d dec_valid seen", i), 64'(ok), 64'd1);
      check($sformatf("v%0d latency", i), 64'(lat), 64'd2);
      check($sformatf("v%0d data", i), 64'(bus.dec_data_out), 64'(vecs[i].exp_data));
      check($sformatf("v%0d sbit", i), 64'(bus.dec_sbit_err), 64'(vecs[i].exp_s));
      check($sformatf("v%0d dbit", i), 64'(bus.dec_dbit_err), 64'(vecs[i].exp_d));
      check($sformatf("v%0d tag", i), 64'(bus.dec_tag_out), 64'(8'hA0 + i));
      @(posedge clk); #1;
      check($sformatf("v%0d sbit_cnt", i), 64'(bus.sbit_cnt), 64'(vecs[i].exp_s));
      check($sformatf("v%0d dbit_cnt", i), 64'(bus.dbit_cnt), 64'(vecs[i].exp_d));
      check($sformatf("v%0d log_valid", i), 64'(bus.err_log_valid),
            64'(vecs[i].exp_s | vecs[i].exp_d));
      if (vecs[i].exp_s || vecs[i].exp_d) begin
        check($sformatf("v%0d log_syn", i), 64'(bus.err_log_syndrome), 64'(vecs[i].exp_syn));
        check($sformatf("v%0d log_dbit", i), 64'(bus.err_log_dbit), 64'(vecs[i].exp_d));
        check($sformatf("v%0d log_tag", i), 64'(bus.err_log_tag), 64'(8'hA0 + i));
      end
    end

    // Log capture, dbit overwrite, hold, bypass leaves stats alone
    clear_stats();
    run_word(30'h2AAAAAAA, 1'b1, 37'h10, 1'b0, 8'h11, ok, lat);
    @(posedge clk); #1;
    check("seq1 sbit_cnt", 64'(bus.sbit_cnt), 64'd1);
    check("seq1 log_syn", 64'(bus.err_log_syndrome), 64'h49);
    check("seq1 log_tag", 64'(bus.err_log_tag), 64'h11);
    check("seq1 log_dbit", 64'(bus.err_log_dbit), 64'd0);
    run_word(30'h2AAAAAAA, 1'b1, 37'h3, 1'b0, 8'h22, ok, lat);
    check("seq2 data", 64'(bus.dec_data_out), 64'h2AAAAAA9);
    check("seq2 dbit", 64'(bus.dec_dbit_err), 64'd1);
    @(posedge clk); #1;
    check("seq2 dbit_cnt", 64'(bus.dbit_cnt), 64'd1);
    check("seq2 log_dbit", 64'(bus.err_log_dbit), 64'd1);
    check("seq2 log_syn", 64'(bus.err_log_syndrome), 64'h06);
    check("seq2 log_tag", 64'(bus.err_log_tag), 64'h22);
    run_word(30'h2AAAAAAA, 1'b1, 37'h20000000, 1'b0, 8'h33, ok, lat);
    @(posedge clk); #1;
    check("seq3 sbit_cnt", 64'(bus.sbit_cnt), 64'd2);
    check("seq3 log holds", 64'(bus.err_log_tag), 64'h22);
    run_word(30'h2AAAAAAA, 1'b1, 37'h10, 1'b1, 8'h44, ok, lat);
    check("seq4 bypass data", 64'(bus.dec_data_out), 64'h2AAAAABA);
    check("seq4 bypass flags", 64'({bus.dec_sbit_err, bus.dec_dbit_err}), 64'd0);
    @(posedge clk); #1;
    check("seq4 counters", 64'({bus.sbit_cnt, bus.dbit_cnt}), 64'h0002_0001);

    // Back-to-back single errors: saturation in the 2-bit copy
    clear_stats();
    bus.enc_data_in  = 30'h2AAAAAAA;
    bus.inject_en    = 1'b1;
    bus.inject_mask  = 37'h10;
    bus.bypass       = 1'b0;
    bus.dec_tag_in   = 8'h5A;
    bus.enc_valid_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.enc_valid_in = 1'b0;
    bus.inject_en    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("sat small sbit_cnt", 64'(bus_s.sbit_cnt), 64'd3);
    check("sat wide sbit_cnt", 64'(bus.sbit_cnt), 64'd5);
    check("sat small log_syn", 64'(bus_s.err_log_syndrome), 64'h49);

    // stat_clr on the same edge an error would be counted
    run_word(30'h2AAAAAAA, 1'b1, 37'h10, 1'b0, 8'h55, ok, lat);
    check("clr error present", 64'(bus.dec_sbit_err & bus.dec_valid_out), 64'd1);
    clear_stats();
    check("clr small sbit_cnt", 64'(bus_s.sbit_cnt), 64'd0);
    check("clr small log_valid", 64'(bus_s.err_log_valid), 64'd0);
    check("clr wide sbit_cnt", 64'(bus.sbit_cnt), 64'd0);
    check("clr data kept", 64'(bus.dec_data_out), 64'h2AAAAAAA);
    @(posedge clk); #1;
    check("clr stays 0", 64'(bus_s.sbit_cnt), 64'd0);

    // Reset with two words in flight
    run_word(30'h2AAAAAAA, 1'b1, 37'h3, 1'b0, 8'h66, ok, lat);
    bus.inject_en    = 1'b1;
    bus.inject_mask  = 37'h10;
    bus.enc_valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.enc_valid_in = 1'b0;
    bus.inject_en    = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-rst dec_valid c%0d", k), 64'(bus.dec_valid_out), 64'd0);
    end
    check("post-rst counters", 64'({bus.sbit_cnt, bus.dbit_cnt}), 64'd0);
    check("post-rst log", 64'({bus.err_log_valid, bus.err_log_dbit, bus.err_log_syndrome,
                                bus.err_log_tag}), 64'd0);
    check("post-rst flags", 64'({bus.dec_sbit_err, bus.dec_dbit_err}), 64'd0);
    check("post-rst small", 64'({bus_s.sbit_cnt, bus_s.dbit_cnt, bus_s.err_log_valid}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SECDED encoder/decoder for FIFO/RAM words of any DATA_WIDTH.
- Encoder generates check bits on the write side. Decoder corrects single-bit errors and flags double-bit errors on the read side.
- Adds a registered valid-qualified pipeline, test error injection, saturating error counters and a first-error log.
- Sits between FIFO control logic and storage arrays.

Parameters:
- DATA_WIDTH, 30, data bits per word (>=4).
- PARITY_WIDTH, 7, check bits. Must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH. Elaboration error otherwise.
- TAG_WIDTH, 8, sideband tag (e.g. address) carried with each decode.
- CNT_WIDTH, 16, error counter width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- enc_valid_in  in  1  encode request
- enc_data_in  in  DATA_WIDTH  data to encode
- inject_en  in  1  apply inject_mask to encoder output
- inject_mask  in  DATA_WIDTH+PARITY_WIDTH  XOR mask on {parity,data}, data in LSBs
- enc_valid_out  out  1  encode result valid
- enc_data_out  out  DATA_WIDTH  stored data (possibly corrupted)
- enc_parity_out  out  PARITY_WIDTH  stored check bits (possibly corrupted)
- dec_valid_in  in  1  decode request
- dec_data_in  in  DATA_WIDTH  data read from storage
- dec_parity_in  in  PARITY_WIDTH  check bits read from storage
- dec_tag_in  in  TAG_WIDTH  sideband tag
- bypass  in  1  disable correction and flagging
- dec_valid_out  out  1  decode result valid
- dec_data_out  out  DATA_WIDTH  corrected data
- dec_tag_out  out  TAG_WIDTH  tag aligned with data
- dec_sbit_err  out  1  corrected single-bit error, qualified by dec_valid_out
- dec_dbit_err  out  1  uncorrectable error, qualified by dec_valid_out
- stat_clr  in  1  clear counters and log
- sbit_cnt  out  CNT_WIDTH  saturating single-error count
- dbit_cnt  out  CNT_WIDTH  saturating double-error count
- err_log_valid  out  1  log holds an entry
- err_log_dbit  out  1  logged entry is uncorrectable
- err_log_syndrome  out  PARITY_WIDTH  logged syndrome
- err_log_tag  out  TAG_WIDTH  logged tag

Behaviour:
- Reset: every output and internal register is 0.
- Code definition:
  - Data bit i maps to h_i, the i-th integer >=3 that is not a power of two, ascending (h_0=3, h_1=5, h_2=6, h_3=7, h_4=9, ...).
  - For k < PARITY_WIDTH-1: p[k] = XOR of d[i] over all i where bit k of h_i is 1.
  - p[PARITY_WIDTH-1] = XOR of all data bits and p[PARITY_WIDTH-2:0].
- Encoder: latency 1.
  - enc_valid_out = enc_valid_in delayed one cycle.
  - Data/parity outputs update only when enc_valid_in=1 and hold otherwise.
  - When inject_en=1, {parity,data} is XORed with inject_mask.
- Decoder: latency 2, fully pipelined, one word per cycle, no backpressure.
  - Stage 1 registers the received word, tag, bypass, syndrome s = recomputed Hamming bits ^ received low bits, and overall parity mismatch m.
  - Stage 2 registers the corrected outputs.
  - Pipeline registers load only on valid. The valid bit shifts every cycle.
- Classification (stage 2), with s as the low PARITY_WIDTH-1 syndrome bits:
  - s=0, m=0: clean.
  - m=1 and s equals some h_i: flip d[i], sbit=1.
  - m=1 and s is 0 or a power of two: check-bit error, data unchanged, sbit=1.
  - m=0 and s!=0: dbit=1, data unchanged.
  - m=1 and s is not a valid position (beyond last h_i): dbit=1, data unchanged.
- bypass (sampled with the word in stage 1): data passes unchanged, both flags 0, no counter or log update.
- Counters:
  - On dec_valid_out with sbit, sbit_cnt increments. On dbit, dbit_cnt increments.
  - Counters saturate at all-ones, no wrap.
- Log:
  - Captures syndrome ({m,s}), tag and dbit on the first error while err_log_valid=0.
  - A dbit error overwrites a logged sbit entry. Otherwise the log holds.
- stat_clr: has priority. Counters and log clear that cycle, and any error event in the same cycle is not recorded. Data outputs are unaffected.
- Reset mid-stream: in-flight words are discarded and dec_valid_out=0 on the first edge after reset deasserts.

Test Plan:
- Encode 30'h2AAAAAAA, no inject, loop to decoder -> 2 cycles later dec_data_out=30'h2AAAAAAA, both flags 0, counters 0.
- Same word, inject_mask bit 4 -> dec_data_out=30'h2AAAAAAA, dec_sbit_err=1, sbit_cnt=1, err_log_syndrome low 6 bits=6'd9, err_log_tag=dec_tag_in.
- inject bits 0 and 1 -> dec_dbit_err=1, data=30'h2AAAAAA9, dbit_cnt=1, err_log_dbit=1 (overwrites the earlier sbit log).
- inject parity bit 0 only (mask bit 30) -> data unchanged, sbit=1.
- inject parity bit 6 only (mask bit 36) -> data unchanged, sbit=1.
- bypass=1 with bit-4 error -> dec_data_out=30'h2AAAAABA, flags 0, counters unchanged.
- CNT_WIDTH=2: five back-to-back single errors -> sbit_cnt saturates at 3. Then stat_clr coincident with an error -> sbit_cnt=0, err_log_valid=0.
- Assert rst with two words in flight -> no dec_valid_out afterwards, all status outputs 0.
